butterfly_pipe: RTL and testbench
=================================

// Module: butterfly_pipe
// PURPOSE
//  Pipelined, parametrised complex radix-2 DIT butterfly: A = a + W*b, B = a - W*b.
//  Twiddle multiply, rounding, optional per-stage /2 scaling and output saturation.
//  Valid/ready streaming with full back-pressure; one butterfly per cycle.
//  Sits between the FFT stage data RAM and the twiddle ROM in each SIMD FFT lane.
// PARAMETERS
//  DW   15  signed data width for a, b, A and B (real and imaginary parts)
//  TW   12  signed twiddle width, Q1.(TW-1) format (+1.0 is not representable)
// PORTS
//  clk        in   1   rising-edge clock; single clock domain
//  rst_n      in   1   asynchronous reset, active low
//  in_valid   in   1   input operands valid
//  in_ready   out  1   block accepts operands this cycle
//  ar, ai     in   DW  operand a, real/imag, signed
//  br, bi     in   DW  operand b, real/imag, signed
//  wr, wi     in   TW  twiddle W, real/imag, signed
//  scale      in   1   1 = divide results by 2 (sampled with operands)
//  out_valid  out  1   results valid
//  out_ready  in   1   downstream accepts results
//  Ar, Ai     out  DW  A = a + W*b, signed, saturated
//  Br, Bi     out  DW  B = a - W*b, signed, saturated
//  ovf        out  1   sticky: any output saturated since last clear
//  ovf_clr    in   1   synchronous clear of ovf (clear wins over same-cycle set)
// BEHAVIOUR
//  Reset (async assert, sync release): all stage valids, out_valid, ovf = 0; data
//   regs and Ar/Ai/Br/Bi = 0; in_ready = 1 after reset.
//  Transfer occurs on a cycle with valid & ready both high, at each port.
//  Pipeline: 3 register stages, latency 3 cycles from accepted input to out_valid
//   with no stall. Stage valid bits v1, v2, v3 (v3 = out_valid).
//  Global stall: adv = !v3 | out_ready; in_ready = adv. All stages load only when
//   adv = 1; when adv = 0 every stage holds data and valid. No bubble is inserted
//   when adv = 1. Throughput is 1 per cycle with out_ready held high.
//  S1: pr = br*wr - bi*wi; pi = br*wi + bi*wr, full width DW+TW+1. Register a, scale.
//  S2: round half-up: p = (pX + 2^(TW-2)) >>> (TW-1), kept DW+2 bits (no sat).
//  S3: sA = a + p, sB = a - p at DW+3 bits; if scale: s = (s + 1) >>> 1.
//      Saturate to [-2^(DW-1), 2^(DW-1)-1]; ovf <= 1 if any of 4 parts clipped
//      and the S3 load is valid.
//  ovf set only on valid S3 loads; ovf_clr & set same cycle -> ovf = 0.
//  Outputs stable while out_valid & !out_ready (held per the stall rule).
//  in_valid = 0 with adv = 1 shifts a bubble (v1 <= 0); data regs may update.
//  Reset mid-operation discards all in-flight butterflies; no partial output.
//  scale, wr/wi sampled only on accepted input; changing them later has no effect
//   on in-flight data.
// TESTING (DW=15, TW=12)
//  1 W=(2047,0), a=(1000,0), b=(100,0), scale=0 -> after 3 clk A=(1100,0),
//    B=(900,0), ovf=0.
//  2 W=(0,-2048) (=-j), a=(0,0), b=(100,50), scale=0 -> A=(50,-100), B=(-50,100).
//  3 W=(2047,0), a=b=(16000,0), scale=0 -> A=(16383,0) saturated, B=(8,0), ovf=1;
//    repeat with scale=1 -> A=(15996,0), B=(4,0); ovf stays 1 until ovf_clr pulse.
//  4 Stream 8 back-to-back inputs, out_ready=1 -> 8 results on 8 consecutive
//    cycles, in order. Then hold out_ready=0 for 5 clk while driving 3 inputs ->
//    in_ready low once full; no loss, no duplication, outputs stable during stall.
//  5 ovf_clr asserted in the same cycle a saturating result loads -> ovf=0 next cycle.
//  6 Assert rst_n=0 mid-stream with 3 in flight -> out_valid=0 and ovf=0
//    immediately (async); after release no stale results emerge.

Source files
------------

// File: rtl/butterfly_pipe.sv
// Pipelined complex radix-2 DIT butterfly: A = a + W*b, B = a - W*b.
// Three register stages (multiply, round, add/scale/saturate) under one
// global stall signal, so the whole pipe either advances or holds.
module butterfly_pipe #(
  parameter int DW = 15,
  parameter int TW = 12
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] ar,
  input  logic signed [DW-1:0] ai,
  input  logic signed [DW-1:0] br,
  input  logic signed [DW-1:0] bi,
  input  logic signed [TW-1:0] wr,
  input  logic signed [TW-1:0] wi,
  input  logic                 scale,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [DW-1:0] Ar,
  output logic signed [DW-1:0] Ai,
  output logic signed [DW-1:0] Br,
  output logic signed [DW-1:0] Bi,
  output logic                 ovf,
  input  logic                 ovf_clr
);

  localparam int PW = DW + TW + 1;  // full product-sum width
  localparam int QW = DW + 2;       // rounded product width
  localparam int SW = DW + 3;       // add/sub width

  // Half an LSB of the Q1.(TW-1) result, for round half-up.
  localparam logic signed [PW-1:0] RND_C = {{(PW-TW+1){1'b0}}, 1'b1, {(TW-2){1'b0}}};
  localparam logic signed [SW-1:0] ONE_C = {{(SW-1){1'b0}}, 1'b1};
  localparam logic signed [SW-1:0] MAX_C = {{(SW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [SW-1:0] MIN_C = {{(SW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  function automatic logic signed [PW-1:0] sx_data(input logic signed [DW-1:0] x);
    return {{(PW-DW){x[DW-1]}}, x};
  endfunction

  function automatic logic signed [PW-1:0] sx_twid(input logic signed [TW-1:0] x);
    return {{(PW-TW){x[TW-1]}}, x};
  endfunction

  // Optional divide-by-two with round half-up.
  function automatic logic signed [SW-1:0] half_fn(input logic signed [SW-1:0] s,
                                                   input logic sc);
    if (sc) begin
      return (s + ONE_C) >>> 1;
    end else begin
      return s;
    end
  endfunction

  // Returns {clipped, saturated value}.
  function automatic logic [DW:0] sat_fn(input logic signed [SW-1:0] s);
    if (s > MAX_C) begin
      return {1'b1, 1'b0, {(DW-1){1'b1}}};
    end else if (s < MIN_C) begin
      return {1'b1, 1'b1, {(DW-1){1'b0}}};
    end else begin
      return {1'b0, s[DW-1:0]};
    end
  endfunction

  logic                 adv_s;
  logic                 v1_q, v2_q, v3_q, ovf_q, clip_d;
  logic                 sc1_q, sc2_q;
  logic signed [PW-1:0] pr_d, pi_d, pr_q, pi_q;
  logic signed [DW-1:0] a1r_q, a1i_q, a2r_q, a2i_q;
  logic signed [QW-1:0] p2r_d, p2i_d, p2r_q, p2i_q;
  logic signed [SW-1:0] ar_x_s, ai_x_s, pr_x_s, pi_x_s;
  logic [DW:0]          sat_ar_s, sat_ai_s, sat_br_s, sat_bi_s;
  logic signed [DW-1:0] Ar_d, Ai_d, Br_d, Bi_d, Ar_q, Ai_q, Br_q, Bi_q;

  assign adv_s = !v3_q | out_ready;

  // Next-state datapath for all three stages.
  always_comb begin
    pr_d   = sx_data(br) * sx_twid(wr) - sx_data(bi) * sx_twid(wi);
    pi_d   = sx_data(br) * sx_twid(wi) + sx_data(bi) * sx_twid(wr);
    p2r_d  = QW'((pr_q + RND_C) >>> (TW - 1));
    p2i_d  = QW'((pi_q + RND_C) >>> (TW - 1));
    ar_x_s = {{(SW-DW){a2r_q[DW-1]}}, a2r_q};
    ai_x_s = {{(SW-DW){a2i_q[DW-1]}}, a2i_q};
    pr_x_s = {{(SW-QW){p2r_q[QW-1]}}, p2r_q};
    pi_x_s = {{(SW-QW){p2i_q[QW-1]}}, p2i_q};
    sat_ar_s = sat_fn(half_fn(ar_x_s + pr_x_s, sc2_q));
    sat_ai_s = sat_fn(half_fn(ai_x_s + pi_x_s, sc2_q));
    sat_br_s = sat_fn(half_fn(ar_x_s - pr_x_s, sc2_q));
    sat_bi_s = sat_fn(half_fn(ai_x_s - pi_x_s, sc2_q));
    Ar_d   = sat_ar_s[DW-1:0];
    Ai_d   = sat_ai_s[DW-1:0];
    Br_d   = sat_br_s[DW-1:0];
    Bi_d   = sat_bi_s[DW-1:0];
    clip_d = sat_ar_s[DW] | sat_ai_s[DW] | sat_br_s[DW] | sat_bi_s[DW];
  end

  // Pipeline registers: every stage loads together on adv, otherwise holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q  <= 1'b0;  v2_q  <= 1'b0;  v3_q  <= 1'b0;
      sc1_q <= 1'b0;  sc2_q <= 1'b0;
      pr_q  <= '0;    pi_q  <= '0;
      a1r_q <= '0;    a1i_q <= '0;
      a2r_q <= '0;    a2i_q <= '0;
      p2r_q <= '0;    p2i_q <= '0;
      Ar_q  <= '0;    Ai_q  <= '0;    Br_q <= '0;    Bi_q <= '0;
    end else if (adv_s) begin
      v1_q  <= in_valid;
      pr_q  <= pr_d;   pi_q  <= pi_d;
      a1r_q <= ar;     a1i_q <= ai;   sc1_q <= scale;
      v2_q  <= v1_q;
      p2r_q <= p2r_d;  p2i_q <= p2i_d;
      a2r_q <= a1r_q;  a2i_q <= a1i_q; sc2_q <= sc1_q;
      v3_q  <= v2_q;
      Ar_q  <= Ar_d;   Ai_q  <= Ai_d;  Br_q <= Br_d;  Bi_q <= Bi_d;
    end
  end

  // Sticky overflow flag: set by a valid saturating S3 load, clear has priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (ovf_clr) begin
      ovf_q <= 1'b0;
    end else if (adv_s && v2_q && clip_d) begin
      ovf_q <= 1'b1;
    end
  end

  assign in_ready  = adv_s;
  assign out_valid = v3_q;
  assign ovf       = ovf_q;
  assign Ar        = Ar_q;
  assign Ai        = Ai_q;
  assign Br        = Br_q;
  assign Bi        = Bi_q;

endmodule

// File: tb/tb_butterfly_pipe.sv
// Self-checking bench for butterfly_pipe (DW=15, TW=12): directed vector table,
// multi-cycle stall/clear/reset sequences and randomized traffic against a model.
module tb_butterfly_pipe;

  logic clk = 1'b0;
  logic rst_n, in_valid, in_ready, scale, out_valid, out_ready, ovf, ovf_clr;
  logic signed [14:0] ar, ai, br, bi;
  logic signed [11:0] wr, wi;
  logic signed [14:0] dut_Ar, dut_Ai, dut_Br, dut_Bi;

  butterfly_pipe #(.DW(15), .TW(12)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .ar(ar), .ai(ai), .br(br), .bi(bi), .wr(wr), .wi(wi), .scale(scale),
    .out_valid(out_valid), .out_ready(out_ready),
    .Ar(dut_Ar), .Ai(dut_Ai), .Br(dut_Br), .Bi(dut_Bi),
    .ovf(ovf), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ar, ai, br, bi, wr, wi;
    bit sc;
    int ea_r, ea_i, eb_r, eb_i;
    bit eovf;
  } vec_t;

  typedef struct {
    longint Ar, Ai, Br, Bi;
  } res_t;

  res_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Floor division for a positive divisor.
  function automatic longint fdiv(input longint n, input longint d);
    if (n >= 0) return n / d;
    else return -((-n + d - 1) / d);
  endfunction

  function automatic longint finish_part(input longint s, input bit sc);
    longint v;
    v = sc ? fdiv(s + 1, 2) : s;
    if (v > 16383) v = 16383;
    if (v < -16384) v = -16384;
    return v;
  endfunction

  // Reference: exact complex product, round half-up to Q0, add/sub, scale, clamp.
  function automatic res_t model(input longint a_r, input longint a_i, input longint b_r,
                                 input longint b_i, input longint w_r, input longint w_i,
                                 input bit sc);
    res_t r;
    longint p_r, p_i;
    p_r = fdiv(b_r * w_r - b_i * w_i + 1024, 2048);
    p_i = fdiv(b_r * w_i + b_i * w_r + 1024, 2048);
    r.Ar = finish_part(a_r + p_r, sc);
    r.Ai = finish_part(a_i + p_i, sc);
    r.Br = finish_part(a_r - p_r, sc);
    r.Bi = finish_part(a_i - p_i, sc);
    return r;
  endfunction

  // Scoreboard + stall-stability monitor, sampled on the falling edge.
  bit   hold_v = 1'b0;
  res_t held;
  always @(negedge clk) begin
    res_t e;
    if (!rst_n) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v && out_valid) begin
        chk("stall_stable_Ar", dut_Ar, held.Ar);
        chk("stall_stable_Bi", dut_Bi, held.Bi);
      end
      if (out_valid && !out_ready) begin
        hold_v = 1'b1;
        held.Ar = dut_Ar; held.Ai = dut_Ai; held.Br = dut_Br; held.Bi = dut_Bi;
      end else begin
        hold_v = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("sb_Ar", dut_Ar, e.Ar);
          chk("sb_Ai", dut_Ai, e.Ai);
          chk("sb_Br", dut_Br, e.Br);
          chk("sb_Bi", dut_Bi, e.Bi);
        end
      end
      if (in_valid && in_ready)
        exp_q.push_back(model(ar, ai, br, bi, wr, wi, scale));
    end
  end

  task automatic rand_in();
    ar = 15'($urandom); ai = 15'($urandom);
    br = 15'($urandom); bi = 15'($urandom);
    wr = 12'($urandom); wi = 12'($urandom);
    scale = 1'($urandom);
  endtask

  task automatic set_vec(input vec_t v);
    ar = 15'(v.ar); ai = 15'(v.ai); br = 15'(v.br); bi = 15'(v.bi);
    wr = 12'(v.wr); wi = 12'(v.wi); scale = v.sc;
  endtask

  // Present current operands; returns #1 after the accepting edge.
  task automatic drive_one();
    bit acc;
    acc = 1'b0;
    in_valid = 1'b1;
    for (int t = 0; t < 50 && !acc; t++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    if (!acc) chk("accept_timeout", 0, 1);
  endtask

  task automatic wait_out(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!out_valid && cyc < 20);
    if (!out_valid) chk("out_timeout", 0, 1);
  endtask

  vec_t vt[6];
  int   cyc, cnt;

  initial begin
    vt[0] = '{1000, 0, 100, 0, 2047, 0, 1'b0, 1100, 0, 900, 0, 1'b0};
    vt[1] = '{0, 0, 100, 50, 0, -2048, 1'b0, 50, -100, -50, 100, 1'b0};
    vt[2] = '{16000, 0, 16000, 0, 2047, 0, 1'b0, 16383, 0, 8, 0, 1'b1};
    vt[3] = '{16000, 0, 16000, 0, 2047, 0, 1'b1, 15996, 0, 4, 0, 1'b1};
    vt[4] = '{-16000, 0, -16000, 0, 2047, 0, 1'b0, -16384, 0, -8, 0, 1'b1};
    vt[5] = '{-16000, 0, -16000, 0, 2047, 0, 1'b1, -15996, 0, -4, 0, 1'b1};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; ovf_clr = 1'b0;
    ar = '0; ai = '0; br = '0; bi = '0; wr = '0; wi = '0; scale = 1'b0;
    #3;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_Ar", dut_Ar, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Directed table: value, latency and sticky ovf.
    for (int i = 0; i < 6; i++) begin
      set_vec(vt[i]);
      drive_one();
      in_valid = 1'b0;
      wait_out(cyc);
      chk("latency", cyc, 3);
      chk("tbl_Ar", dut_Ar, vt[i].ea_r);
      chk("tbl_Ai", dut_Ai, vt[i].ea_i);
      chk("tbl_Br", dut_Br, vt[i].eb_r);
      chk("tbl_Bi", dut_Bi, vt[i].eb_i);
      chk("tbl_ovf", ovf, vt[i].eovf);
      @(posedge clk);
      #1;
    end
    ovf_clr = 1'b1;
    @(posedge clk);
    #1 ovf_clr = 1'b0;
    @(negedge clk);
    chk("ovf_cleared", ovf, 0);

    // Eight back-to-back inputs give eight consecutive outputs.
    @(posedge clk);
    #1;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          rand_in();
          drive_one();
        end
        in_valid = 1'b0;
      end
      begin
        cnt = 0;
        do begin
          @(negedge clk);
          cnt++;
        end while (!out_valid && cnt < 20);
        chk("stream_first", out_valid, 1);
        for (int k = 1; k < 8; k++) begin
          @(negedge clk);
          chk("stream_contig", out_valid, 1);
        end
      end
    join
    @(negedge clk);
    chk("stream_end", out_valid, 0);

    // Back-pressure: fill the pipe with out_ready low, a 4th input must wait.
    @(posedge clk);
    #1 out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rand_in();
      drive_one();
    end
    rand_in();
    in_valid = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_out_valid", out_valid, 1);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    drive_one();
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("stall_drain", exp_q.size(), 0);

    // Clear coincident with a saturating load wins.
    set_vec(vt[2]);
    drive_one();
    in_valid = 1'b0;
    @(posedge clk);
    #1 ovf_clr = 1'b1;
    @(posedge clk);
    #1 ovf_clr = 1'b0;
    chk("clr_race_valid", out_valid, 1);
    chk("clr_race_ovf", ovf, 0);
    @(negedge clk);
    chk("clr_race_ovf_after", ovf, 0);

    // Asynchronous reset with three butterflies in flight.
    @(posedge clk);
    #1;
    set_vec(vt[2]);
    drive_one();
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("pre_rst_ovf", ovf, 1);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_vec(vt[4]);
      drive_one();
    end
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", out_valid, 0);
    chk("async_rst_ovf", ovf, 0);
    exp_q.delete();
    @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
    chk("no_stale_after_rst", cnt, 0);

    // Randomized traffic with random back-pressure.
    @(posedge clk);
    for (int c = 0; c < 600; c++) begin
      #1;
      rand_in();
      in_valid  = ($urandom_range(0, 99) < 70);
      out_ready = ($urandom_range(0, 99) < 70);
      @(posedge clk);
    end
    #1 in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("rand_drain", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
